// File: rtl/riscv_types.sv
// Shared pipeline types for the memory stage: execute-to-memory
// control bundle, writeback bundle and access-size encodings.
package riscv_types;

   localparam logic [1:0] MEM_BYTE = 2'b00;
   localparam logic [1:0] MEM_HALF = 2'b01;
   localparam logic [1:0] MEM_WORD = 2'b10;

   typedef struct packed {
      logic       rd_wren;
      logic [4:0] rd_addr;
      logic       mem_wren;
      logic [1:0] mem_size;
      logic       mem_unsign;
      logic       mem_load;
   } memory_info;

   typedef struct packed {
      logic        rd_wren;
      logic [4:0]  rd_addr;
      logic [31:0] rd_data;
   } writeback_info;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } mc_state_t;

endpackage

// File: rtl/memory_cycle_if.sv
// Data-memory request/acknowledge bus between the memory stage
// (master) and the data memory (slave).
interface memory_cycle_if;

   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [3:0]  dmem_be_o;
   logic [31:0] dmem_wdata_o;
   logic        dmem_ack_i;
   logic [31:0] dmem_rdata_i;

   modport master (
      output dmem_req_o, dmem_we_o, dmem_addr_o,
      output dmem_be_o, dmem_wdata_o,
      input  dmem_ack_i, dmem_rdata_i
   );

   modport slave (
      input  dmem_req_o, dmem_we_o, dmem_addr_o,
      input  dmem_be_o, dmem_wdata_o,
      output dmem_ack_i, dmem_rdata_i
   );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables / replicated write data and
// load lane extraction with sign or zero extension.
module lsu_align
   import riscv_types::*;
(
   input  logic [1:0]  i_size,
   input  logic        i_unsign,
   input  logic [1:0]  i_off,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_ldata
);

   logic [15:0] w_lane;
   logic        w_sext;

   always_comb begin
      w_lane  = 16'(i_rdata >> {i_off, 3'b000});
      w_sext  = 1'b0;
      o_be    = 4'b1111;
      o_wdata = i_wdata;
      o_ldata = i_rdata;
      unique case (1'b1)
         (i_size == MEM_BYTE): begin
            w_sext  = w_lane[7] & ~i_unsign;
            o_be    = 4'b0001 << i_off;
            o_wdata = {4{i_wdata[7:0]}};
            o_ldata = {{24{w_sext}}, w_lane[7:0]};
         end
         (i_size == MEM_HALF): begin
            w_sext  = w_lane[15] & ~i_unsign;
            o_be    = 4'b0011 << i_off;
            o_wdata = {2{i_wdata[15:0]}};
            o_ldata = {{16{w_sext}}, w_lane};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/memory_cycle.sv
// Memory pipeline stage: issues data-memory accesses, stalls the
// front end while waiting for ack, and registers the writeback bundle.
module memory_cycle
   import riscv_types::*;
#(
   parameter int DMEM_TIMEOUT = 16
)
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  memory_info           memory_signals,
   input  logic [31:0]          Result_M,
   input  logic [31:0]          rs2_data_M,
   memory_cycle_if.master       dmem,
   output logic                 stall_o,
   output logic [4:0]           rd_addr_M,
   output logic                 rd_wren_M,
   output logic [4:0]           rd_addr_W,
   output logic                 rd_wren_W,
   output logic [31:0]          rd_data_W,
   output logic                 misalign_o,
   output logic                 bus_err_o
);

   localparam int CW = $clog2(DMEM_TIMEOUT + 1);

   mc_state_t     r_state;
   mc_state_t     w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   writeback_info r_wb;
   logic          r_misalign;
   logic          r_bus_err;

   logic        w_memop;
   logic        w_misalign;
   logic        w_aligned;
   logic        w_req;
   logic        w_stall;
   logic        w_timeout;
   logic [1:0]  w_off;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [31:0] w_ldata;

   assign w_off   = Result_M[1:0];
   assign w_memop = memory_signals.mem_load
                  | memory_signals.mem_wren;
   assign w_misalign = w_memop &
      (((memory_signals.mem_size == MEM_HALF) & w_off[0]) |
       ((memory_signals.mem_size >= MEM_WORD) & (|w_off)));
   assign w_aligned = w_memop & ~w_misalign;

   lsu_align u_align (
      .i_size   (memory_signals.mem_size),
      .i_unsign (memory_signals.mem_unsign),
      .i_off    (w_off),
      .i_wdata  (rs2_data_M),
      .i_rdata  (dmem.dmem_rdata_i),
      .o_be     (w_be),
      .o_wdata  (w_wdata),
      .o_ldata  (w_ldata)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
         ST_IDLE: begin
            w_cnt_nxt = '0;
            if (w_aligned & ~dmem.dmem_ack_i)
               w_state_nxt = ST_BUSY;
         end
         ST_BUSY: begin
            if (dmem.dmem_ack_i | w_timeout) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // The timeout cycle releases the stall so the faulting op retires
   always_comb begin
      w_req     = 1'b0;
      w_stall   = 1'b0;
      w_timeout = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            w_req   = w_aligned;
            w_stall = w_aligned & ~dmem.dmem_ack_i;
         end
         ST_BUSY: begin
            w_req     = 1'b1;
            w_timeout = ~dmem.dmem_ack_i &
                        (r_cnt == CW'(DMEM_TIMEOUT - 1));
            w_stall   = ~dmem.dmem_ack_i & ~w_timeout;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wb       <= '0;
         r_misalign <= 1'b0;
         r_bus_err  <= 1'b0;
      end else begin
         r_misalign <= w_misalign;
         r_bus_err  <= w_timeout;
         if (w_stall) begin
            r_wb <= '0;
         end else begin
            r_wb.rd_wren <= memory_signals.rd_wren
                          & ~w_misalign & ~w_timeout;
            r_wb.rd_addr <= memory_signals.rd_addr;
            r_wb.rd_data <= memory_signals.mem_load
                          ? w_ldata : Result_M;
         end
      end
   end

   assign dmem.dmem_req_o   = w_req;
   assign dmem.dmem_we_o    = memory_signals.mem_wren;
   assign dmem.dmem_addr_o  = {Result_M[31:2], 2'b00};
   assign dmem.dmem_be_o    = w_be;
   assign dmem.dmem_wdata_o = w_wdata;

   assign stall_o    = w_stall;
   assign rd_addr_M  = memory_signals.rd_addr;
   assign rd_wren_M  = memory_signals.rd_wren;
   assign rd_addr_W  = r_wb.rd_addr;
   assign rd_wren_W  = r_wb.rd_wren;
   assign rd_data_W  = r_wb.rd_data;
   assign misalign_o = r_misalign;
   assign bus_err_o  = r_bus_err;

endmodule

// File: doc/memory_cycle.md
MEMORY_CYCLE -- requirements
Module: memory_cycle

Interface
REQ-001 SHALL have parameter DMEM_TIMEOUT, default 16: BUSY cycles without ack before a bus error is declared.
REQ-002 SHALL have port clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  in  1  reset; synchronous, active-high.
REQ-004 SHALL have port memory_signals  in  memory_info  rd_wren, rd_addr, mem_wren, mem_size, mem_unsign, mem_load from execute register.
REQ-005 SHALL have port Result_M  in  32  ALU result / effective address.
REQ-006 SHALL have port rs2_data_M  in  32  store data.
REQ-007 SHALL have port dmem_req_o  out  1  data-memory request.
REQ-008 SHALL have port dmem_we_o  out  1  1 = store, 0 = load.
REQ-009 SHALL have port dmem_addr_o  out  32  word address {Result_M[31:2],2'b00}.
REQ-010 SHALL have port dmem_be_o  out  4  byte enables.
REQ-011 SHALL have port dmem_wdata_o  out  32  lane-replicated store data.
REQ-012 SHALL have port dmem_ack_i  in  1  memory completion, single-cycle pulse.
REQ-013 SHALL have port dmem_rdata_i  in  32  read word, valid with ack.
REQ-014 SHALL have port stall_o  out  1  freezes IF/ID/EX; EX holds its output register while high.
REQ-015 SHALL have port rd_addr_M / rd_wren_M  out  5/1  combinational copies for the forwarding unit.
REQ-016 SHALL have port rd_addr_W / rd_wren_W / rd_data_W  out  5/1/32  registered writeback outputs.
REQ-017 SHALL have port misalign_o / bus_err_o  out  1/1  one-cycle exception pulses.

Function
REQ-018 SHALL treat a cycle as a memory op when mem_load or mem_wren is 1; mem_size 00 byte, 01 half, 10 word; 11 treated as word.
REQ-019 SHALL flag misaligned when half with addr[0]=1 or word with addr[1:0]!=0; such an op issues no request, does not stall, pulses misalign_o and writes W with rd_wren_W=0.
REQ-020 SHALL implement FSM IDLE/BUSY: IDLE drives dmem_req_o combinationally for an aligned memory op; ack in same cycle completes with zero stall; no ack -> BUSY.
REQ-021 SHALL hold dmem_req_o and all dmem_* outputs stable in BUSY until ack; ack -> IDLE.
REQ-022 SHALL assert stall_o = (aligned memory op) AND NOT dmem_ack_i, in IDLE and BUSY.
REQ-023 SHALL count BUSY cycles; on reaching DMEM_TIMEOUT without ack, return to IDLE, pulse bus_err_o, drop request, write W with rd_wren_W=0.
REQ-024 SHALL, on store, set dmem_be_o: byte 4'b0001<<addr[1:0], half 4'b0011<<addr[1:0], word 4'b1111; wdata replicates rs2 byte x4 / half x2 / word.
REQ-025 SHALL, on load, select lane by addr[1:0], sign-extend unless mem_unsign=1, zero-extend otherwise; word ignores mem_unsign.
REQ-026 SHALL update W register every non-stalled cycle: rd_data_W = extracted load data if mem_load else Result_M; rd_wren_W = rd_wren AND no misalign/error; rd_addr_W = rd_addr.
REQ-027 SHALL load a bubble (rd_wren_W=0) into W every cycle stall_o is high.
REQ-028 SHALL ignore dmem_ack_i in IDLE when no request is active.

Reset
REQ-029 SHALL on rst_i=1 at a clock edge: FSM IDLE, counter 0, rd_wren_W=0, rd_addr_W=0, rd_data_W=0, bus_err_o=0, misalign_o=0.
REQ-030 SHALL, on reset mid-BUSY, abandon the access; dmem_req_o low the following cycle; a late ack is ignored.

Structure
REQ-031 SHALL place writeback_info typedef (rd_wren, rd_addr, rd_data) and mem_size encodings in riscv_types; memory_info reused unchanged.
REQ-032 SHALL factor lane extraction/byte-enable generation into sub-module lsu_align (combinational); FSM and W register stay in memory_cycle.

Verification
REQ-033 SHALL cover: lb addr 0x103, rdata 0x80FF_1234, ack same cycle -> rd_data_W=0xFFFF_FF80, stall_o never high.
REQ-034 SHALL cover: lhu addr 0x102, ack after 3 cycles, rdata 0xBEEF_0000 -> stall_o high 3 cycles, three W bubbles, then rd_data_W=0x0000_BEEF.
REQ-035 SHALL cover: sb rs2=0x0000_00AB addr 0x201 -> dmem_be_o=0010, dmem_wdata_o=0xABAB_ABAB, dmem_addr_o=0x200, rd_wren_W=0.
REQ-036 SHALL cover: lw addr 0x102 -> no dmem_req_o, misalign_o one cycle, rd_wren_W=0.
REQ-037 SHALL cover: lw, DMEM_TIMEOUT=4, no ack -> stall 4 cycles, bus_err_o pulse, FSM IDLE; reset asserted in BUSY -> req low next cycle, late ack ignored.
REQ-038 SHALL cover: ALU op add x5 Result_M=0x1234 -> rd_data_W=0x1234, rd_addr_W=5 one cycle later.
